mci_cif_arbiter: RTL and testbench

Two-requester round-robin arbiter with a hang watchdog, placed in front of the MCI AXI subordinate address decoder. It shares the single cif_if request path into the MCI target map (MCI regs, trace buffer, mailboxes, MCU SRAM) between:
- the AXI subordinate (requester 0);
- an internal requester such as the debug/DMA path (requester 1).

It adds zero latency to uncontended accesses, keeps ownership locked while a target holds, and aborts with an error any transaction that a target holds longer than a programmable limit.

---
 rtl/cif_if.sv | 15 +
 rtl/mci_cif_arbiter.sv | 112 +++++++++++
 tb/tb_mci_cif_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cif_if.sv
// Request/response bundle between a requester and the MCI target decoder.
// "request" drives the access, "response" answers it.
interface cif_if #(
    parameter int REQ_W  = 64,
    parameter int DATA_W = 32
);
    logic              dv;
    logic [REQ_W-1:0]  req_data;
    logic              hold;
    logic [DATA_W-1:0] rdata;
    logic              error;

    modport request  (output dv, req_data, input  hold, rdata, error);
    modport response (input  dv, req_data, output hold, rdata, error);
endinterface

// File: rtl/mci_cif_arbiter.sv
// Two-requester round-robin arbiter in front of the MCI target decoder, with
// ownership locking across target holds and a hang watchdog that aborts with error.
module mci_cif_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int WD_WIDTH       = 16
) (
    input  logic       clk,
    input  logic       rst,
    cif_if.response    req0_if,
    cif_if.response    req1_if,
    cif_if.request     tgt_if,
    output logic       gnt_id,
    output logic       busy,
    output logic       timeout_pulse,
    output logic [7:0] timeout_cnt
);
    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    localparam logic [WD_WIDTH-1:0] TIMEOUT_LIM = WD_WIDTH'(TIMEOUT_CYCLES);
    localparam bit                  WD_EN       = (TIMEOUT_CYCLES != 0);

    state_t              state, state_nxt;
    logic                rr_last;
    logic [WD_WIDTH-1:0] wd_cnt, wd_cnt_nxt;
    logic                active, sel, done, abort;
    logic                fwd, own0, own1;

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        active     = 1'b0;
        sel        = gnt_id;
        state_nxt  = state;
        wd_cnt_nxt = '0;
        done       = 1'b0;
        abort      = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0_if.dv || req1_if.dv) begin
                    active = 1'b1;
                    // Contention goes to whoever did not finish last.
                    sel = (req0_if.dv && req1_if.dv) ? ~rr_last : req1_if.dv;
                    if (tgt_if.hold) begin
                        state_nxt  = sel ? LOCK1 : LOCK0;
                        wd_cnt_nxt = WD_WIDTH'(1);
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            LOCK0, LOCK1: begin
                active = 1'b1;
                sel    = (state == LOCK1);
                if (!(sel ? req1_if.dv : req0_if.dv)) begin
                    state_nxt = IDLE;
                end else if (!tgt_if.hold) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (WD_EN && wd_cnt >= TIMEOUT_LIM) begin
                    abort     = 1'b1;
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wd_cnt_nxt = (wd_cnt == '1) ? wd_cnt : wd_cnt + WD_WIDTH'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset gates the forward path so nothing reaches a target mid-reset.
    assign fwd  = active && !rst;
    assign own0 = fwd && !sel;
    assign own1 = fwd && sel;

    assign tgt_if.dv       = fwd && !abort && (sel ? req1_if.dv : req0_if.dv);
    assign tgt_if.req_data = sel ? req1_if.req_data : req0_if.req_data;

    assign req0_if.hold  = own0 ? (tgt_if.hold && !abort) : 1'b1;
    assign req0_if.rdata = (own0 && !abort) ? tgt_if.rdata : '0;
    assign req0_if.error = own0 && (abort || tgt_if.error);

    assign req1_if.hold  = own1 ? (tgt_if.hold && !abort) : 1'b1;
    assign req1_if.rdata = (own1 && !abort) ? tgt_if.rdata : '0;
    assign req1_if.error = own1 && (abort || tgt_if.error);

    assign timeout_pulse = abort && !rst;
    assign busy          = (state != IDLE);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_last     <= 1'b1;
            wd_cnt      <= '0;
            gnt_id      <= 1'b0;
            timeout_cnt <= '0;
        end else begin
            state  <= state_nxt;
            wd_cnt <= wd_cnt_nxt;
            if (active) gnt_id <= sel;
            if (done) rr_last <= sel;
            if (abort && timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
        end
    end

    // A locked owner must keep dv up until the target releases it.
    owner_holds_dv: assert property (@(posedge clk) disable iff (rst)
        (state != IDLE) |-> ((state == LOCK1) ? req1_if.dv : req0_if.dv));

endmodule

// File: tb/tb_mci_cif_arbiter.sv
// Directed bench: one arbiter with the watchdog off for arbitration/lock/reset
// cases, one with TIMEOUT_CYCLES=4 for abort and counter saturation.
module tb_mci_cif_arbiter;
    typedef struct packed {
        logic        dv0;
        logic        dv1;
        logic [63:0] d0;
        logic [63:0] d1;
        logic        hold;
        logic [31:0] rdata;
        logic        err;
    } stim_t;

    logic  clk = 1'b0;
    logic  rst;
    stim_t sa, sb;
    int    n_cmp = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    cif_if r0a(), r1a(), tgt_a();
    cif_if r0b(), r1b(), tgt_b();

    assign r0a.dv = sa.dv0;   assign r0a.req_data = sa.d0;
    assign r1a.dv = sa.dv1;   assign r1a.req_data = sa.d1;
    assign tgt_a.hold = sa.hold; assign tgt_a.rdata = sa.rdata; assign tgt_a.error = sa.err;
    assign r0b.dv = sb.dv0;   assign r0b.req_data = sb.d0;
    assign r1b.dv = sb.dv1;   assign r1b.req_data = sb.d1;
    assign tgt_b.hold = sb.hold; assign tgt_b.rdata = sb.rdata; assign tgt_b.error = sb.err;

    logic       gnt_a, busy_a, to_a, gnt_b, busy_b, to_b;
    logic [7:0] tcnt_a, tcnt_b;

    mci_cif_arbiter #(.TIMEOUT_CYCLES(0), .WD_WIDTH(16)) u_nowd (
        .clk(clk), .rst(rst), .req0_if(r0a), .req1_if(r1a), .tgt_if(tgt_a),
        .gnt_id(gnt_a), .busy(busy_a), .timeout_pulse(to_a), .timeout_cnt(tcnt_a));

    mci_cif_arbiter #(.TIMEOUT_CYCLES(4), .WD_WIDTH(16)) u_wd (
        .clk(clk), .rst(rst), .req0_if(r0b), .req1_if(r1b), .tgt_if(tgt_b),
        .gnt_id(gnt_b), .busy(busy_b), .timeout_pulse(to_b), .timeout_cnt(tcnt_b));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic bad;
        sa  = '0;
        sb  = '0;
        rst = 1'b1;

        // Reset: forward path blocked even with a request pending
        sa.dv0 = 1'b1;
        #1;
        check("rst_tgt_dv", 64'(tgt_a.dv), 64'd0);
        check("rst_req0_hold", 64'(r0a.hold), 64'd1);
        check("rst_req1_hold", 64'(r1a.hold), 64'd1);
        tick();
        tick();
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_gnt", 64'(gnt_a), 64'd0);
        check("rst_tcnt", 64'(tcnt_b), 64'd0);
        sa.dv0 = 1'b0;
        rst    = 1'b0;
        tick();

        // Single-cycle read by req0 at address 0
        sa.dv0 = 1'b1; sa.d0 = 64'h0; sa.hold = 1'b0; sa.rdata = 32'hDEAD_BEEF;
        #1;
        check("rd_tgt_dv", 64'(tgt_a.dv), 64'd1);
        check("rd_tgt_data", tgt_a.req_data, 64'h0);
        check("rd_req0_rdata", 64'(r0a.rdata), 64'hDEAD_BEEF);
        check("rd_req0_hold", 64'(r0a.hold), 64'd0);
        check("rd_req1_hold", 64'(r1a.hold), 64'd1);
        tick();
        check("rd_busy", 64'(busy_a), 64'd0);
        check("rd_gnt", 64'(gnt_a), 64'd0);
        sa.dv0 = 1'b0;

        // Contention right after reset: alternation 0,1,0,1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sa.dv0 = 1'b1; sa.dv1 = 1'b1; sa.d0 = 64'hA0A0; sa.d1 = 64'hB1B1; sa.rdata = 32'h55;
        #1;
        check("ct0_data", tgt_a.req_data, 64'hA0A0);
        check("ct0_req1_hold", 64'(r1a.hold), 64'd1);
        check("ct0_req1_rdata", 64'(r1a.rdata), 64'd0);
        tick();
        check("ct1_data", tgt_a.req_data, 64'hB1B1);
        check("ct1_req1_hold", 64'(r1a.hold), 64'd0);
        check("ct1_req0_hold", 64'(r0a.hold), 64'd1);
        check("ct1_gnt", 64'(gnt_a), 64'd0);
        tick();
        check("ct2_data", tgt_a.req_data, 64'hA0A0);
        check("ct2_gnt", 64'(gnt_a), 64'd1);
        tick();
        check("ct3_data", tgt_a.req_data, 64'hB1B1);
        tick();
        sa.dv0 = 1'b0; sa.dv1 = 1'b0;
        tick();

        // Locked hold: req1 held 5 cycles, req0 arrives in cycle 2
        sa.dv1 = 1'b1; sa.d1 = 64'hC0DE; sa.hold = 1'b1;
        #1;
        check("lk_tgt_data", tgt_a.req_data, 64'hC0DE);
        check("lk_req1_hold", 64'(r1a.hold), 64'd1);
        tick();
        sa.dv0 = 1'b1; sa.d0 = 64'hD00D;
        bad = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            #1;
            if (!r0a.hold || !busy_a || tgt_a.req_data !== 64'hC0DE) bad = 1'b1;
            tick();
        end
        check("lk_req0_blocked", 64'(bad), 64'd0);
        sa.hold = 1'b0; sa.rdata = 32'h1234_5678; sa.err = 1'b1;
        #1;
        check("lk_c6_req1_rdata", 64'(r1a.rdata), 64'h1234_5678);
        check("lk_c6_req1_err", 64'(r1a.error), 64'd1);
        check("lk_c6_req0_err", 64'(r0a.error), 64'd0);
        check("lk_c6_req0_hold", 64'(r0a.hold), 64'd1);
        tick();
        check("lk_c7_gnt", 64'(gnt_a), 64'd1);
        sa.dv1 = 1'b0; sa.err = 1'b0;
        #1;
        check("lk_c7_data", tgt_a.req_data, 64'hD00D);
        check("lk_c7_req0_hold", 64'(r0a.hold), 64'd0);
        check("lk_c7_busy", 64'(busy_a), 64'd0);
        tick();
        check("lk_c8_gnt", 64'(gnt_a), 64'd0);
        sa.dv0 = 1'b0;
        tick();

        // Watchdog disabled: 5000 hold cycles, then normal completion
        sa.dv0 = 1'b1; sa.hold = 1'b1;
        bad = 1'b0;
        for (int c = 1; c <= 5000; c++) begin
            #1;
            if (to_a || !r0a.hold) bad = 1'b1;
            tick();
        end
        check("nowd_no_abort", 64'(bad), 64'd0);
        check("nowd_busy", 64'(busy_a), 64'd1);
        sa.hold = 1'b0; sa.rdata = 32'hCAFE;
        #1;
        check("nowd_rdata", 64'(r0a.rdata), 64'hCAFE);
        tick();
        check("nowd_done", 64'(busy_a), 64'd0);
        check("nowd_tcnt", 64'(tcnt_a), 64'd0);
        sa.dv0 = 1'b0;
        tick();

        // Reset in cycle 3 of a held req1 transaction
        sa.dv1 = 1'b1; sa.d1 = 64'hE1; sa.hold = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rml_tgt_dv", 64'(tgt_a.dv), 64'd0);
        check("rml_req1_hold", 64'(r1a.hold), 64'd1);
        tick();
        check("rml_busy", 64'(busy_a), 64'd0);
        check("rml_wd_cnt", 64'(u_nowd.wd_cnt), 64'd0);
        rst = 1'b0;
        sa.dv0 = 1'b1; sa.d0 = 64'hE0; sa.hold = 1'b0;
        #1;
        check("rml_first_req0", tgt_a.req_data, 64'hE0);
        check("rml_req1_wait", 64'(r1a.hold), 64'd1);
        tick();
        check("rml_then_req1", tgt_a.req_data, 64'hE1);
        sa.dv0 = 1'b0; sa.dv1 = 1'b0;
        tick();

        // Watchdog abort with TIMEOUT_CYCLES=4
        sb.dv0 = 1'b1; sb.hold = 1'b1; sb.rdata = 32'hBAD0;
        #1;
        check("wd_c1_tgt_dv", 64'(tgt_b.dv), 64'd1);
        bad = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            if (to_b || !r0b.hold) bad = 1'b1;
            tick();
        end
        check("wd_no_early_abort", 64'(bad), 64'd0);
        check("wd_c5_req0_hold", 64'(r0b.hold), 64'd0);
        check("wd_c5_req0_err", 64'(r0b.error), 64'd1);
        check("wd_c5_req0_rdata", 64'(r0b.rdata), 64'd0);
        check("wd_c5_tgt_dv", 64'(tgt_b.dv), 64'd0);
        check("wd_c5_pulse", 64'(to_b), 64'd1);
        tick();
        check("wd_tcnt1", 64'(tcnt_b), 64'd1);
        check("wd_busy", 64'(busy_b), 64'd0);

        // 299 further aborts saturate the counter at 255
        for (int a = 0; a < 299; a++) begin
            repeat (5) tick();
        end
        check("wd_tcnt_sat", 64'(tcnt_b), 64'd255);
        sb.dv0 = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
